// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Shares the register file's single write port between two writeback
// requesters (A = ALU/EXE result, B = memory-load result) with round-robin
// arbitration, and keeps a per-register pending-write scoreboard that the
// decode stage queries to stall on outstanding writes.
//
// Handshake: a transfer happens in a cycle where valid && ready. The
// requester keeps valid/addr/data stable until it sees ready; ready is
// combinational and never depends on ready of the other side.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   a_valid/a_addr/a_data requester A write request, a_ready = accepted
//   b_valid/b_addr/b_data requester B write request, b_ready = accepted
//   wr_en/wr_addr/wr_data registered, single-cycle write pulse to the RF
//   mark_en/mark_addr     decode marks a destination as pending
//   q_addr1/q_busy1       scoreboard query 1 (combinational)
//   q_addr2/q_busy2       scoreboard query 2 (combinational)
//   sb_ovf                sticky flag: a mark was dropped at saturation
module reg_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] q_addr1,
    output logic              q_busy1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              q_busy2,
    output logic              sb_ovf
);

    localparam int              NREG    = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              r_rr_last_b;   // 1: B won the last grant
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [CNT_W-1:0]  r_cnt [NREG];
    logic              r_sb_ovf;

    logic              w_accept_ok;
    logic              w_grant_a;
    logic              w_grant_b;
    logic [NREG-1:0]   w_mark_hit;
    logic [NREG-1:0]   w_commit_hit;

    // The RF commits on the falling edge of its enable, so no accept is
    // allowed while a pulse is on the port.
    assign w_accept_ok = !rst && !r_wr_en;
    assign w_grant_a   = w_accept_ok && a_valid && (!b_valid || r_rr_last_b);
    assign w_grant_b   = w_accept_ok && b_valid && (!a_valid || !r_rr_last_b);

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign sb_ovf  = r_sb_ovf;

    // Write port: a grant to a nonzero address produces a one-cycle pulse.
    // A grant to register 0 is consumed without a pulse, so the port stays
    // free and the next accept can follow immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last_b <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_grant_a) begin
                r_rr_last_b <= 1'b0;
                if (a_addr != '0) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= a_addr;
                    r_wr_data <= a_data;
                end
            end else if (w_grant_b) begin
                r_rr_last_b <= 1'b1;
                if (b_addr != '0) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= b_addr;
                    r_wr_data <= b_data;
                end
            end
        end
    end

    // Per-register decode of marks and commits; register 0 never matches.
    always_comb begin
        w_mark_hit   = '0;
        w_commit_hit = '0;
        for (int i = 1; i < NREG; i++) begin
            w_mark_hit[i]   = mark_en && (mark_addr == ADDR_W'(i));
            w_commit_hit[i] = r_wr_en && (r_wr_addr == ADDR_W'(i));
        end
    end

    // Scoreboard counters. A mark and a commit to the same register in the
    // same cycle cancel, which also means no overflow at saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_sb_ovf <= 1'b0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_mark_hit[i] && !w_commit_hit[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_sb_ovf <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end else if (w_commit_hit[i] && !w_mark_hit[i]) begin
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - CNT_ONE;
                    end
                end
            end
        end
    end

    // A write on the port this cycle is forwarded by the RF, so the last
    // outstanding write to a register no longer stalls its readers.
    assign q_busy1 = (q_addr1 != '0) && (r_cnt[q_addr1] != '0) &&
                     !(r_wr_en && (r_wr_addr == q_addr1) && (r_cnt[q_addr1] == CNT_ONE));
    assign q_busy2 = (q_addr2 != '0) && (r_cnt[q_addr2] != '0) &&
                     !(r_wr_en && (r_wr_addr == q_addr2) && (r_cnt[q_addr2] == CNT_ONE));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, mark_en;
    logic [2:0]  a_addr, b_addr, mark_addr, q_addr1, q_addr2, wr_addr;
    logic [15:0] a_data, b_data, wr_data;
    logic        a_ready, b_ready, wr_en, q_busy1, q_busy2, sb_ovf;

    reg_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .q_addr1(q_addr1), .q_busy1(q_busy1),
        .q_addr2(q_addr2), .q_busy2(q_busy2),
        .sb_ovf(sb_ovf)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // staged inputs for the next cycle
    bit          s_rst, s_av, s_bv, s_me;
    logic [2:0]  s_aa, s_ba, s_ma, s_q1, s_q2;
    logic [15:0] s_ad, s_bd;

    // sampled DUT outputs of the last cycle
    bit          obs_ar, obs_br, obs_we, obs_b1, obs_b2, obs_ovf;
    logic [2:0]  obs_wa;
    logic [15:0] obs_wd;

    // ---------------- reference model ----------------
    // Expected port state, pending-write counts and round-robin memory.
    bit          m_we, m_last_b, m_ovf;
    int          m_wa, m_wd;
    int          m_cnt [8];
    bit          e_ar, e_br;
    logic [18:0] exp_q [$];   // {addr,data} of writes the RF must see, in order

    function automatic void model_reset();
        m_we = 0; m_wa = 0; m_wd = 0; m_last_b = 1; m_ovf = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        exp_q.delete();
    endfunction

    function automatic bit m_busy(input int q);
        if (q == 0 || m_cnt[q] == 0) return 0;
        if (m_we && m_wa == q && m_cnt[q] == 1) return 0;
        return 1;
    endfunction

    function automatic void model_advance();
        int ca;
        ca = m_we ? m_wa : 0;
        if (s_me && s_ma != 0 && int'(s_ma) != ca) begin
            if (m_cnt[s_ma] == 3) m_ovf = 1;
            else m_cnt[s_ma] = m_cnt[s_ma] + 1;
        end
        if (ca != 0 && !(s_me && int'(s_ma) == ca) && m_cnt[ca] > 0)
            m_cnt[ca] = m_cnt[ca] - 1;
        m_we = 0;
        if (e_ar) begin
            m_last_b = 0;
            if (s_aa != 0) begin m_we = 1; m_wa = s_aa; m_wd = s_ad; exp_q.push_back({s_aa, s_ad}); end
        end else if (e_br) begin
            m_last_b = 1;
            if (s_ba != 0) begin m_we = 1; m_wa = s_ba; m_wd = s_bd; exp_q.push_back({s_ba, s_bd}); end
        end
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        logic [18:0] w;
        @(negedge clk);
        rst = s_rst; a_valid = s_av; a_addr = s_aa; a_data = s_ad;
        b_valid = s_bv; b_addr = s_ba; b_data = s_bd;
        mark_en = s_me; mark_addr = s_ma; q_addr1 = s_q1; q_addr2 = s_q2;
        if (s_rst) model_reset();
        #1;
        obs_ar = a_ready; obs_br = b_ready; obs_we = wr_en; obs_wa = wr_addr;
        obs_wd = wr_data; obs_b1 = q_busy1; obs_b2 = q_busy2; obs_ovf = sb_ovf;
        e_ar = !s_rst && !m_we && s_av && (!s_bv || m_last_b);
        e_br = !s_rst && !m_we && s_bv && (!s_av || !m_last_b);
        chk("m_a_ready", obs_ar, e_ar);
        chk("m_b_ready", obs_br, e_br);
        chk("m_wr_en", obs_we, m_we);
        chk("m_wr_addr", obs_wa, m_wa);
        chk("m_wr_data", obs_wd, m_wd);
        chk("m_busy1", obs_b1, m_busy(s_q1));
        chk("m_busy2", obs_b2, m_busy(s_q2));
        chk("m_sb_ovf", obs_ovf, m_ovf);
        if (obs_we) begin
            if (exp_q.size() == 0) chk("sb_unexpected_write", 1, 0);
            else begin
                w = exp_q.pop_front();
                chk("sb_write", {obs_wa, obs_wd}, w);
            end
        end
        @(posedge clk);
        if (!s_rst) model_advance();
    endtask

    task automatic idle_inputs();
        s_rst = 0; s_av = 0; s_aa = 0; s_ad = 0; s_bv = 0; s_ba = 0; s_bd = 0;
        s_me = 0; s_ma = 0; s_q1 = 0; s_q2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); s_rst = 1; step(); s_rst = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit av; logic [2:0] aa; logic [15:0] ad;
        bit bv; logic [2:0] ba; logic [15:0] bd;
        bit me; logic [2:0] ma; logic [2:0] q1; logic [2:0] q2;
        bit ear; bit ebr; bit ewe; logic [2:0] ewa; logic [15:0] ewd; bit eb1; bit eb2;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int accepts, consec, last_side;
        bit pa, pb, prev_we;

        rst = 1; a_valid = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;
        mark_en = 0; mark_addr = 0; q_addr1 = 0; q_addr2 = 0;
        model_reset();

        //          rst av aa ad       bv ba bd        me ma q1 q2  ar br we wa wd       b1 b2
        vecs[0]  = '{0, 1, 3, 16'h1234, 0, 0, 16'h0,    0, 0, 3, 0,  1, 0, 0, 0, 16'h0,    0, 0};
        vecs[1]  = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3, 0,  0, 0, 1, 3, 16'h1234, 0, 0};
        vecs[2]  = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3, 0,  0, 0, 0, 3, 16'h1234, 0, 0};
        vecs[3]  = '{1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0,  0, 0, 0, 0, 16'h0,    0, 0};
        vecs[4]  = '{0, 1, 1, 16'h0001, 1, 2, 16'h0002, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0,    0, 0};
        vecs[5]  = '{0, 0, 0, 16'h0,    1, 2, 16'h0002, 0, 0, 0, 0,  0, 0, 1, 1, 16'h0001, 0, 0};
        vecs[6]  = '{0, 0, 0, 16'h0,    1, 2, 16'h0002, 0, 0, 0, 0,  0, 1, 0, 1, 16'h0001, 0, 0};
        vecs[7]  = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0,  0, 0, 1, 2, 16'h0002, 0, 0};
        vecs[8]  = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0,  0, 0, 0, 2, 16'h0002, 0, 0};
        vecs[9]  = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 5, 5, 5,  0, 0, 0, 2, 16'h0002, 0, 0};
        vecs[10] = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 5, 5, 5,  0, 0, 0, 2, 16'h0002, 1, 1};
        vecs[11] = '{0, 1, 5, 16'h0055, 0, 0, 16'h0,    0, 0, 5, 5,  1, 0, 0, 2, 16'h0002, 1, 1};
        vecs[12] = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 5, 5,  0, 0, 1, 5, 16'h0055, 1, 1};
        vecs[13] = '{0, 1, 5, 16'h0066, 0, 0, 16'h0,    0, 0, 5, 5,  1, 0, 0, 5, 16'h0055, 1, 1};
        vecs[14] = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 5, 5,  0, 0, 1, 5, 16'h0066, 0, 0};
        vecs[15] = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 5, 5,  0, 0, 0, 5, 16'h0066, 0, 0};
        vecs[16] = '{0, 0, 0, 16'h0,    1, 0, 16'hFFFF, 0, 0, 0, 0,  0, 1, 0, 5, 16'h0066, 0, 0};
        vecs[17] = '{0, 1, 6, 16'h0ABC, 0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 5, 16'h0066, 0, 0};
        vecs[18] = '{0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0,  0, 0, 1, 6, 16'h0ABC, 0, 0};

        // reset state
        do_reset();
        chk("rst_wr_en", obs_we, 0);
        chk("rst_wr_addr", obs_wa, 0);
        chk("rst_wr_data", obs_wd, 0);
        chk("rst_sb_ovf", obs_ovf, 0);

        // table: single write, tie after reset, scoreboard drain, address 0
        for (int i = 0; i < 19; i++) begin
            s_rst = vecs[i].rst; s_av = vecs[i].av; s_aa = vecs[i].aa; s_ad = vecs[i].ad;
            s_bv = vecs[i].bv; s_ba = vecs[i].ba; s_bd = vecs[i].bd;
            s_me = vecs[i].me; s_ma = vecs[i].ma; s_q1 = vecs[i].q1; s_q2 = vecs[i].q2;
            step();
            chk($sformatf("v%0d_a_ready", i), obs_ar, vecs[i].ear);
            chk($sformatf("v%0d_b_ready", i), obs_br, vecs[i].ebr);
            chk($sformatf("v%0d_wr_en", i), obs_we, vecs[i].ewe);
            chk($sformatf("v%0d_wr_addr", i), obs_wa, vecs[i].ewa);
            chk($sformatf("v%0d_wr_data", i), obs_wd, vecs[i].ewd);
            chk($sformatf("v%0d_busy1", i), obs_b1, vecs[i].eb1);
            chk($sformatf("v%0d_busy2", i), obs_b2, vecs[i].eb2);
        end

        // saturation: four marks to r4, then mark+commit at max
        do_reset();
        idle_inputs(); s_me = 1; s_ma = 4; s_q1 = 4;
        repeat (4) step();
        idle_inputs(); s_q1 = 4; step();
        chk("sat_busy", obs_b1, 1);
        chk("sat_ovf", obs_ovf, 1);
        s_av = 1; s_aa = 4; s_ad = 16'h0444; step();
        idle_inputs(); s_q1 = 4; s_me = 1; s_ma = 4; step();   // commit and mark together
        chk("sat_mc_we", obs_we, 1);
        chk("sat_mc_busy", obs_b1, 1);
        for (int k = 0; k < 2; k++) begin
            idle_inputs(); s_q1 = 4; s_av = 1; s_aa = 4; s_ad = 16'(k); step();
            idle_inputs(); s_q1 = 4; step();
        end
        idle_inputs(); s_q1 = 4; step();
        chk("sat_left_one_busy", obs_b1, 1);
        chk("sat_ovf_sticky", obs_ovf, 1);

        // both requesters continuously valid for 12 cycles
        do_reset();
        accepts = 0; consec = 0; last_side = 1; prev_we = 0;
        idle_inputs();
        s_av = 1; s_aa = 3'($urandom_range(1, 7)); s_ad = 16'($urandom);
        s_bv = 1; s_ba = 3'($urandom_range(1, 7)); s_bd = 16'($urandom);
        for (int c = 0; c < 12; c++) begin
            step();
            if (obs_we && prev_we) consec++;
            prev_we = obs_we;
            if (obs_ar || obs_br) begin
                chk("rr_alternate", obs_br, !last_side);
                last_side = obs_br;
                accepts++;
            end
            if (obs_ar) begin s_aa = 3'($urandom_range(1, 7)); s_ad = 16'($urandom); end
            if (obs_br) begin s_ba = 3'($urandom_range(1, 7)); s_bd = 16'($urandom); end
        end
        chk("rr_accepts", accepts, 6);
        chk("rr_no_back_to_back", consec, 0);

        // reset during a write pulse
        do_reset();
        idle_inputs(); s_me = 1; s_ma = 7; s_q1 = 7; step();
        s_av = 1; s_aa = 7; s_ad = 16'h7777; step();
        #1;
        chk("pre_rst_wr_en", wr_en, 1);
        chk("pre_rst_busy", q_busy1, 1);
        idle_inputs(); s_rst = 1; s_q1 = 7; s_q2 = 7; step();
        chk("mid_rst_wr_en", obs_we, 0);
        chk("mid_rst_busy1", obs_b1, 0);
        chk("mid_rst_busy2", obs_b2, 0);
        do_reset();

        // randomized traffic against the model
        pa = 0; pb = 0;
        idle_inputs();
        for (int c = 0; c < 800; c++) begin
            s_rst = ($urandom_range(0, 199) == 0);
            if (!pa && $urandom_range(0, 1) == 1) begin
                pa = 1; s_aa = 3'($urandom_range(0, 7)); s_ad = 16'($urandom);
            end
            if (!pb && $urandom_range(0, 1) == 1) begin
                pb = 1; s_ba = 3'($urandom_range(0, 7)); s_bd = 16'($urandom);
            end
            s_av = pa; s_bv = pb;
            s_me = ($urandom_range(0, 3) == 0); s_ma = 3'($urandom_range(0, 7));
            s_q1 = 3'($urandom_range(0, 7)); s_q2 = 3'($urandom_range(0, 7));
            step();
            if (e_ar || s_rst) pa = 0;
            if (e_br || s_rst) pb = 0;
        end
        idle_inputs();
        repeat (3) step();
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A, the ALU/EXE result, and B, the memory-load result. Arbitration is round-robin. The write port is registered and pulsed so that each write is committed on the falling edge of the write enable.
The block also holds a per-register pending-write scoreboard that the decode stage queries to stall on outstanding writes. It sits between the pipeline writeback paths and the register file write inputs (writable/write_addr/write_value).

Parameters:
DATA_W, 16, width of register value
ADDR_W, 3, width of register address; 2**ADDR_W registers, address 0 is the zero register
CNT_W, 2, width of each scoreboard pending counter

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous reset, active-high
a_valid  in  1  requester A has a write
a_addr  in  ADDR_W  requester A destination
a_data  in  DATA_W  requester A value
a_ready  out  1  A accepted this cycle (combinational)
b_valid  in  1  requester B has a write
b_addr  in  ADDR_W  requester B destination
b_data  in  DATA_W  requester B value
b_ready  out  1  B accepted this cycle (combinational)
wr_en  out  1  to register file writable
wr_addr  out  ADDR_W  to register file write_addr
wr_data  out  DATA_W  to register file write_value
mark_en  in  1  decode issued an instruction that will write mark_addr
mark_addr  in  ADDR_W  destination being marked pending
q_addr1  in  ADDR_W  scoreboard query 1
q_busy1  out  1  q_addr1 has an uncommitted write (combinational)
q_addr2  in  ADDR_W  scoreboard query 2
q_busy2  out  1  as q_busy1 for q_addr2
sb_ovf  out  1  sticky: mark dropped because counter saturated

Behaviour:
- Reset (async, rst=1): wr_en=0, wr_addr=0, wr_data=0, all counters=0, sb_ovf=0, rr_last=B (so A wins the first tie). a_ready and b_ready are forced 0 while rst=1.
- Port pacing: accept is allowed only when wr_en=0 in the current cycle. The register file commits on the falling edge of its enable, so there is at least one idle cycle between writes: at most 1 accept per 2 cycles.
- Grant, when accept is allowed:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not rr_last.
  - rr_last updates to the granted side on each grant.
  - ready = grant; a transfer is valid&&ready. A requester holds valid/addr/data until it sees ready.
- Latency: accept in cycle N gives wr_en=1, wr_addr/wr_data = accepted values in cycle N+1 only. wr_en returns to 0 in N+2. wr_addr/wr_data hold their last values while wr_en=0.
- Address 0: the request is accepted (ready=1) and rr_last updates, but wr_en stays 0 next cycle. Since no write pulse is generated, the next accept may occur in N+1.
- Scoreboard: one CNT_W counter per register. Register 0 is never counted and never reported busy.
  - mark_en && mark_addr!=0: counter +1. If the counter is already at max (3), the mark is dropped and sb_ovf is set until reset.
  - Commit (wr_en=1 in a cycle): counter[wr_addr] -1, saturating at 0. A commit to a counter at 0 is silently ignored.
  - Mark and commit to the same address in the same cycle: counter unchanged, and no overflow even if the counter is at max.
- Busy: q_busyK = (cnt[q]!=0) && !(wr_en && wr_addr==q && cnt[q]==1). A write being committed this cycle is already visible through register file forwarding, so it does not stall.
- Reset mid-operation: an in-flight wr_en pulse is cancelled immediately and all pending counts are lost; upstream flushes its pipeline on rst.

Test Plan:
1. Reset, then A: valid, addr=3, data=0x1234 for one cycle -> a_ready=1 in cycle 0; wr_en=1, wr_addr=3, wr_data=0x1234 in cycle 1; wr_en=0 in cycle 2.
2. A and B both held valid (A→r1=0x0001, B→r2=0x0002) from reset -> A accepted cycle 0, B accepted cycle 2; wr_en high in cycles 1 and 3 only; both readys 0 in cycles 1 and 3.
3. Both requesters continuously valid for 12 cycles -> grants alternate A,B,A,B,A,B (6 accepts); no two consecutive wr_en=1 cycles.
4. mark r5 twice, then commit A r5 once -> q_busy1(r5)=1. During the second commit's wr_en cycle q_busy1=0; after that the counter is 0.
5. mark r4 four times without commit -> counter=3, sb_ovf=1 and stays 1. mark r4 together with a commit to r4 at counter=3 -> counter stays 3, no new effect.
6. B writes addr 0 with data 0xFFFF -> b_ready=1, wr_en stays 0, and a following A request is accepted in the next cycle. Assert rst during a wr_en=1 cycle -> wr_en=0 immediately and all q_busy=0.
